// File: rtl/mips64_pkg.sv
// rtl/mips64_pkg.sv - shared types and constants for the MIPS64 memory port arbiter
package mips64_pkg;

    localparam int REG_SZ = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_MA = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_MA = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - per-transaction cycle counter that flags a memory access that never acks
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    // cnt holds completed BUSY cycles, so this marks the TIMEOUT-th cycle itself
    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IF and MA with MA priority and IF starvation guard
module mem_port_arbiter
    import mips64_pkg::*;
#(
    parameter int ADDR_W        = REG_SZ,
    parameter int DATA_W        = REG_SZ,
    parameter int MAX_MA_STREAK = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ma_req,
    input  logic              ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic              ma_ack,
    output logic              ma_err,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [7:0] STREAK_MAX = 8'(MAX_MA_STREAK);

    arb_state_e state;
    logic [7:0] ma_streak;
    logic       ma_win;
    logic       busy;
    logic       wd_expired;

    assign busy   = (state == BUSY_IF) || (state == BUSY_MA);
    assign ma_win = ma_req && !(if_req && (ma_streak == STREAK_MAX));

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!busy),
        .en      (busy),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ma_streak <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            ma_ack    <= 1'b0;
            ma_err    <= 1'b0;
            ma_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ma_win) begin
                        state     <= BUSY_MA;
                        mem_req   <= 1'b1;
                        mem_we    <= ma_we;
                        mem_addr  <= ma_addr;
                        mem_wdata <= ma_wdata;
                        // the streak only grows while IF is actually being held off
                        if (!if_req) begin
                            ma_streak <= '0;
                        end else if (ma_streak != STREAK_MAX) begin
                            ma_streak <= ma_streak + 8'd1;
                        end
                    end else if (if_req) begin
                        state     <= BUSY_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        ma_streak <= '0;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        if_ack   <= 1'b1;
                        if_err   <= 1'b0;
                        if_rdata <= mem_rdata;
                    end else if (wd_expired) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        if_ack   <= 1'b1;
                        if_err   <= 1'b1;
                        if_rdata <= '0;
                    end
                end
                BUSY_MA: begin
                    if (mem_ack) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        ma_ack   <= 1'b1;
                        ma_err   <= 1'b0;
                        ma_rdata <= mem_we ? '0 : mem_rdata;
                    end else if (wd_expired) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        ma_ack   <= 1'b1;
                        ma_err   <= 1'b1;
                        ma_rdata <= '0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    if_ack <= 1'b0;
                    if_err <= 1'b0;
                    ma_ack <= 1'b0;
                    ma_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mips64_pkg::*;

    localparam int TMO    = 8;
    localparam int STREAK = 4;
    localparam int NEVER  = 1000;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mem_txn_t;

    typedef struct {
        logic        port;
        logic        err;
        logic [63:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, ma_req, ma_we, mem_ack;
    logic [63:0] if_addr, ma_addr, ma_wdata, mem_rdata;
    logic        if_ack, if_err, ma_ack, ma_err, mem_req, mem_we;
    logic [63:0] if_rdata, ma_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .MAX_MA_STREAK(STREAK), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_ack(ma_ack), .ma_err(ma_err), .ma_rdata(ma_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int n_vec = 0;
    int n_miss = 0;

    mem_txn_t    exp_mem_q[$];
    resp_t       exp_resp_q[$];
    logic [63:0] if_stim_q[$];
    mem_txn_t    ma_stim_q[$];

    int mem_lat = 0;
    bit force_ack = 0;
    bit scribble = 0;
    int last_busy = 0;
    int if_ack_cnt = 0;
    int ma_ack_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_data(input logic [63:0] a);
        return (a == 64'h100) ? 64'hDEADBEEF : (a ^ 64'hC3C3_0000_1234_5678);
    endfunction

    task automatic exp_if(input logic [63:0] a, input logic err);
        exp_mem_q.push_back('{1'b0, a, 64'h0});
        exp_resp_q.push_back('{REQ_IF, err, err ? 64'h0 : mk_data(a)});
    endtask

    task automatic exp_ma(input logic we, input logic [63:0] a, input logic [63:0] wd, input logic err);
        exp_mem_q.push_back('{we, a, wd});
        exp_resp_q.push_back('{REQ_MA, err, (err || we) ? 64'h0 : mk_data(a)});
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while ((if_stim_q.size() != 0 || ma_stim_q.size() != 0 || if_req || ma_req ||
                mem_req || exp_resp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_time"}, 64'(n < budget), 64'd1);
        check({tag, "_mem_q_empty"}, 64'(exp_mem_q.size()), 64'd0);
        exp_mem_q.delete();
        exp_resp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // memory responder: checks each granted access and its stability, acks after mem_lat cycles
    initial begin : mem_model
        mem_txn_t e, cur;
        int  wcnt;
        bit  in_txn;
        wcnt = 0;
        in_txn = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack = force_ack;
            mem_rdata = '0;
            if (mem_req) begin
                if (!in_txn) begin
                    in_txn = 1;
                    wcnt = 0;
                    cur.we = mem_we;
                    cur.addr = mem_addr;
                    cur.wdata = mem_wdata;
                    if (exp_mem_q.size() == 0) begin
                        check("mem_unexpected_req", 64'd1, 64'd0);
                    end else begin
                        e = exp_mem_q.pop_front();
                        check("mem_we", 64'(mem_we), 64'(e.we));
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_wdata", mem_wdata, e.wdata);
                    end
                end else begin
                    check("mem_addr_stable", mem_addr, cur.addr);
                    check("mem_wdata_stable", mem_wdata, cur.wdata);
                end
                if (wcnt == mem_lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mk_data(mem_addr);
                end
                wcnt++;
            end else if (in_txn) begin
                in_txn = 0;
                last_busy = wcnt;
            end
        end
    end

    initial begin : resp_mon
        resp_t e;
        forever begin
            @(negedge clk);
            if (if_ack) begin
                if_ack_cnt++;
                if (exp_resp_q.size() == 0) begin
                    check("if_unexpected_ack", 64'd1, 64'd0);
                end else begin
                    e = exp_resp_q.pop_front();
                    check("if_ack_port", 64'(REQ_IF), 64'(e.port));
                    check("if_err", 64'(if_err), 64'(e.err));
                    check("if_rdata", if_rdata, e.rdata);
                end
            end
            if (ma_ack) begin
                ma_ack_cnt++;
                if (exp_resp_q.size() == 0) begin
                    check("ma_unexpected_ack", 64'd1, 64'd0);
                end else begin
                    e = exp_resp_q.pop_front();
                    check("ma_ack_port", 64'(REQ_MA), 64'(e.port));
                    check("ma_err", 64'(ma_err), 64'(e.err));
                    check("ma_rdata", ma_rdata, e.rdata);
                end
            end
        end
    end

    initial begin : if_requester
        int taken;
        taken = 0;
        if_req = 1'b0;
        if_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                if_req = 1'b0;
                taken = if_ack_cnt;
            end else begin
                if (if_req && taken != if_ack_cnt) begin
                    if_req = 1'b0;
                    taken = if_ack_cnt;
                end
                if (!if_req && if_stim_q.size() != 0) begin
                    if_addr = if_stim_q.pop_front();
                    if_req = 1'b1;
                end
            end
        end
    end

    initial begin : ma_requester
        mem_txn_t s;
        int taken;
        taken = 0;
        ma_req = 1'b0;
        ma_we = 1'b0;
        ma_addr = '0;
        ma_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                ma_req = 1'b0;
                taken = ma_ack_cnt;
            end else begin
                if (ma_req && taken != ma_ack_cnt) begin
                    ma_req = 1'b0;
                    taken = ma_ack_cnt;
                end else if (ma_req && scribble) begin
                    ma_addr = ma_addr + 64'h8;
                    ma_wdata = ~ma_wdata;
                end
                if (!ma_req && ma_stim_q.size() != 0) begin
                    s = ma_stim_q.pop_front();
                    ma_we = s.we;
                    ma_addr = s.addr;
                    ma_wdata = s.wdata;
                    ma_req = 1'b1;
                end
            end
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int n, start;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_if_ack", 64'(if_ack), 64'd0);
        check("rst_ma_ack", 64'(ma_ack), 64'd0);
        check("rst_errs", 64'({if_err, ma_err, mem_we}), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_rdata", if_rdata | ma_rdata | mem_wdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single IF read, memory acks one cycle after mem_req
        mem_lat = 1;
        exp_if(64'h100, 1'b0);
        if_stim_q.push_back(64'h100);
        wait_quiet("single_if", 50);

        // simultaneous requests: MA store goes first
        mem_lat = 0;
        exp_ma(1'b1, 64'h200, 64'h55, 1'b0);
        exp_if(64'h300, 1'b0);
        ma_stim_q.push_back('{1'b1, 64'h200, 64'h55});
        if_stim_q.push_back(64'h300);
        wait_quiet("simultaneous", 50);

        // starvation guard: 4 MA grants, IF, 4 more MA, IF, remaining MA
        for (int i = 0; i < 10; i++) begin
            ma_stim_q.push_back('{1'b0, 64'h2000 + 64'(i * 8), 64'h0});
        end
        if_stim_q.push_back(64'h1000);
        if_stim_q.push_back(64'h1100);
        for (int i = 0; i < 4; i++) exp_ma(1'b0, 64'h2000 + 64'(i * 8), 64'h0, 1'b0);
        exp_if(64'h1000, 1'b0);
        for (int i = 4; i < 8; i++) exp_ma(1'b0, 64'h2000 + 64'(i * 8), 64'h0, 1'b0);
        exp_if(64'h1100, 1'b0);
        for (int i = 8; i < 10; i++) exp_ma(1'b0, 64'h2000 + 64'(i * 8), 64'h0, 1'b0);
        wait_quiet("starvation", 200);

        // watchdog abort, then a stray late ack must be ignored
        mem_lat = NEVER;
        exp_ma(1'b0, 64'h3000, 64'h0, 1'b1);
        ma_stim_q.push_back('{1'b0, 64'h3000, 64'h0});
        wait_quiet("watchdog", 50);
        check("watchdog_busy_cycles", 64'(last_busy), 64'(TMO));
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_ack_mem_req", 64'(mem_req), 64'd0);
        check("stray_ack_acks", 64'({if_ack, ma_ack}), 64'd0);

        // wait-state memory while the requester keeps changing its inputs
        mem_lat = 5;
        scribble = 1'b1;
        exp_ma(1'b0, 64'h4000, 64'h0, 1'b0);
        exp_ma(1'b1, 64'h4100, 64'hCAFE, 1'b0);
        ma_stim_q.push_back('{1'b0, 64'h4000, 64'h0});
        ma_stim_q.push_back('{1'b1, 64'h4100, 64'hCAFE});
        wait_quiet("wait_state", 100);
        check("wait_state_busy_cycles", 64'(last_busy), 64'd6);
        scribble = 1'b0;

        // reset in the middle of an IF access
        mem_lat = NEVER;
        exp_mem_q.push_back('{1'b0, 64'h5000, 64'h0});
        if_stim_q.push_back(64'h5000);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midop_mem_req_seen", 64'(mem_req), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midop_mem_req_async", 64'(mem_req), 64'd0);
        check("midop_acks_async", 64'({if_ack, ma_ack}), 64'd0);
        repeat (2) @(negedge clk);
        check("midop_mem_q_empty", 64'(exp_mem_q.size()), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // fresh IF after reset, zero-wait memory: ack seen three cycles after push
        mem_lat = 0;
        exp_if(64'h5100, 1'b0);
        start = if_ack_cnt;
        if_stim_q.push_back(64'h5100);
        n = 0;
        while (if_ack_cnt == start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("post_reset_latency", 64'(n), 64'd3);
        wait_quiet("post_reset", 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
